// File: rtl/load_store_unit.sv
// load_store_unit
//   Load/store unit for the single-cycle core. It takes the ALU result as the
//   effective address and rs2 as store data. It drives a req/ready/rvalid
//   data-memory port and formats load results with sign or zero extension.
//   Misaligned and illegal accesses are flagged without touching memory. The
//   core is stalled while a transaction is outstanding, and a missing response
//   is aborted after TIMEOUT cycles.
//
// Ports
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_valid             instruction is a load/store, held until a result pulse
//   i_isStore           1 = store, 0 = load
//   i_funct3            RV32I funct3 (width/sign of the access)
//   i_addr              effective address
//   i_storeData         rs2 value
//   o_memReq/o_memWe    memory request and write enable
//   o_memAddr           word-aligned request address
//   o_memWdata          lane-replicated store data
//   o_memByteEn         byte enables
//   i_memReady          memory accepts the request this cycle
//   i_memRvalid         read data valid
//   i_memRdata          read data
//   o_stall             freeze PC / regfile write
//   o_done              one-cycle completion pulse
//   o_loadData          formatted load result, meaningful while o_done = 1
//   o_misaligned        one-cycle misaligned-access pulse
//   o_illegal           one-cycle illegal-funct3 pulse
//   o_busError          one-cycle response-timeout pulse
module load_store_unit #(
  parameter int TIMEOUT = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_isStore,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_storeData,
  output logic        o_memReq,
  output logic        o_memWe,
  output logic [31:0] o_memAddr,
  output logic [31:0] o_memWdata,
  output logic [3:0]  o_memByteEn,
  input  logic        i_memReady,
  input  logic        i_memRvalid,
  input  logic [31:0] i_memRdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_loadData,
  output logic        o_misaligned,
  output logic        o_illegal,
  output logic        o_busError
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  function automatic logic is_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    if (is_store) ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else          ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                       (f3 == 3'b100) || (f3 == 3'b101);
    return ok;
  endfunction

  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3[1:0])
      2'b01:   ok = (off[0] == 1'b0);
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] wd;
    case (f3[1:0])
      2'b00:   wd = {4{data[7:0]}};
      2'b01:   wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

  function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    logic [31:0]        res;
    lane_b = rdata[{off, 3'b000} +: 8];
    lane_h = rdata[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  res = {{24{lane_b[7]}}, lane_b};
      3'b001:  res = {{16{lane_h[15]}}, lane_h};
      3'b100:  res = {24'd0, lane_b};
      3'b101:  res = {16'd0, lane_h};
      default: res = rdata;
    endcase
    return res;
  endfunction

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              store_p1;
  logic [2:0]        funct3_p1;
  logic [1:0]        offset_p1;
  logic [31:0]       mem_addr_p1;
  logic [31:0]       wdata_p1;
  logic [3:0]        byte_en_p1;
  logic [31:0]       load_data_p2;

  logic              legal, aligned, accept, capture, timeout_hit;

  assign legal       = is_legal(i_isStore, i_funct3);
  assign aligned     = is_aligned(i_funct3, i_addr[1:0]);
  assign timeout_hit = (TIMEOUT != 0) && (tmo_cnt == TIMEOUT_CNT) &&
                       ((state == S_REQ) || (state == S_WAIT));

  always_comb begin
    state_nxt    = state;
    o_memReq     = 1'b0;
    o_stall      = 1'b0;
    o_done       = 1'b0;
    o_illegal    = 1'b0;
    o_misaligned = 1'b0;
    o_busError   = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_valid) begin
          // Illegal funct3 takes priority over the alignment check.
          if (!legal)        o_illegal    = 1'b1;
          else if (!aligned) o_misaligned = 1'b1;
          else begin
            accept    = 1'b1;
            o_stall   = 1'b1;
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        o_memReq = 1'b1;
        o_stall  = 1'b1;
        if (timeout_hit) begin
          o_busError = 1'b1;
          state_nxt  = S_IDLE;
        end else if (i_memReady) begin
          state_nxt = store_p1 ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        o_stall = 1'b1;
        if (timeout_hit) begin
          o_busError = 1'b1;
          state_nxt  = S_IDLE;
        end else if (i_memRvalid) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p1: request fields latched on acceptance; stage p2: formatted load data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      tmo_cnt      <= '0;
      store_p1     <= 1'b0;
      funct3_p1    <= 3'd0;
      offset_p1    <= 2'd0;
      mem_addr_p1  <= 32'd0;
      wdata_p1     <= 32'd0;
      byte_en_p1   <= 4'd0;
      load_data_p2 <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        tmo_cnt     <= '0;
        store_p1    <= i_isStore;
        funct3_p1   <= i_funct3;
        offset_p1   <= i_addr[1:0];
        mem_addr_p1 <= {i_addr[31:2], 2'b00};
        wdata_p1    <= i_isStore ? store_wdata(i_funct3, i_storeData) : 32'd0;
        byte_en_p1  <= i_isStore ? store_byte_en(i_funct3, i_addr[1:0]) : 4'b1111;
      end else if ((state == S_REQ) || (state == S_WAIT)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (capture) begin
        load_data_p2 <= format_load(funct3_p1, offset_p1, i_memRdata);
      end
    end
  end

  assign o_memWe     = (state == S_REQ) && store_p1;
  assign o_memAddr   = mem_addr_p1;
  assign o_memWdata  = wdata_p1;
  assign o_memByteEn = byte_en_p1;
  assign o_loadData  = load_data_p2;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int TIMEOUT = 8;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_isStore = 1'b0;
  logic [2:0]  i_funct3 = 3'd0;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_storeData = 32'd0;
  logic        i_memReady = 1'b0;
  logic        i_memRvalid = 1'b0;
  logic [31:0] i_memRdata = 32'd0;
  logic        o_memReq, o_memWe, o_stall, o_done, o_misaligned, o_illegal, o_busError;
  logic [31:0] o_memAddr, o_memWdata, o_loadData;
  logic [3:0]  o_memByteEn;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_isStore(i_isStore),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_storeData(i_storeData),
    .o_memReq(o_memReq), .o_memWe(o_memWe), .o_memAddr(o_memAddr),
    .o_memWdata(o_memWdata), .o_memByteEn(o_memByteEn), .i_memReady(i_memReady),
    .i_memRvalid(i_memRvalid), .i_memRdata(i_memRdata), .o_stall(o_stall),
    .o_done(o_done), .o_loadData(o_loadData), .o_misaligned(o_misaligned),
    .o_illegal(o_illegal), .o_busError(o_busError)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        stall, req, we, done, ld, mis, ill, berr;
    logic [31:0] addr, wdata, ldata;
    logic [3:0]  be;
  } exp_t;

  exp_t        ex;
  bit          chk_en = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] last_ldata = 32'd0;

  task automatic chk1(input string name, input logic act, input logic expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  // Reference model: plain arithmetic over the access rules.
  function automatic bit m_legal(input bit st, input logic [2:0] f3);
    if (st) return (f3 <= 3'd2);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic bit m_aligned(input logic [2:0] f3, input logic [31:0] addr);
    if (f3[1:0] == 2'd1) return (addr % 2) == 0;
    if (f3[1:0] == 2'd2) return (addr % 4) == 0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] m_be(input bit st, input logic [2:0] f3, input logic [1:0] off);
    if (!st) return 4'hF;
    if (f3 == 3'd0) return 4'(1 << off);
    if (f3 == 3'd1) return 4'(3 << (off & 2'b10));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] data);
    if (f3 == 3'd0) return data[7:0] * 32'h0101_0101;
    if (f3 == 3'd1) return data[15:0] * 32'h0001_0001;
    return data;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] rdata);
    logic [31:0] v;
    if (f3[1:0] == 2'd0) begin
      v = (rdata >> (8 * off)) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (f3[1:0] == 2'd1) begin
      v = (rdata >> (16 * off[1])) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk1("stall", o_stall, ex.stall);
      chk1("memReq", o_memReq, ex.req);
      chk1("memWe", o_memWe, ex.we);
      chk1("done", o_done, ex.done);
      chk1("misaligned", o_misaligned, ex.mis);
      chk1("illegal", o_illegal, ex.ill);
      chk1("busError", o_busError, ex.berr);
      if (ex.req) begin
        chk32("memAddr", o_memAddr, ex.addr);
        chk32("byteEn", {28'd0, o_memByteEn}, {28'd0, ex.be});
        if (ex.we) chk32("memWdata", o_memWdata, ex.wdata);
      end
      if (ex.done && ex.ld) chk32("loadData", o_loadData, ex.ldata);
      if (o_done) last_ldata = o_loadData;
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // One transaction: memory accepts at REQ cycle rdy, returns data rvd cycles later.
  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] rdata,
                         input int rdy, input int rvd, input bit give_rv);
    bit   legal, aligned, abort;
    int   kc, last_k;
    exp_t e;
    legal   = m_legal(st, f3);
    aligned = m_aligned(f3, addr);
    abort   = 1'b0;
    step();
    i_valid = 1'b1; i_isStore = st; i_funct3 = f3; i_addr = addr;
    i_storeData = data; i_memRdata = rdata; i_memReady = 1'b0; i_memRvalid = 1'b0;
    e = idle_exp();
    e.ill   = !legal;
    e.mis   = legal && !aligned;
    e.stall = legal && aligned;
    ex = e;
    if (legal && aligned) begin
      kc     = st ? rdy : (give_rv ? rdy + rvd : 1 << 20);
      abort  = (TIMEOUT != 0) && (kc >= TIMEOUT);
      last_k = abort ? TIMEOUT : kc + 1;
      for (int k = 0; k <= last_k; k++) begin
        step();
        i_memReady  = (k == rdy);
        i_memRvalid = (!st && give_rv && k == rdy + rvd) || (k <= rdy && $urandom_range(0, 1) == 1);
        e = idle_exp();
        if (k == last_k && !abort) begin
          e.done  = 1'b1;
          e.ld    = !st;
          e.ldata = m_load(f3, addr[1:0], rdata);
        end else begin
          e.stall = 1'b1;
          e.req   = (k <= rdy);
          e.we    = e.req && st;
          e.addr  = {addr[31:2], 2'b00};
          e.be    = m_be(st, f3, addr[1:0]);
          e.wdata = m_wd(f3, data);
          e.berr  = abort && (k == last_k);
        end
        ex = e;
      end
    end
    step();
    i_valid = 1'b0; i_memReady = 1'b0;
    i_memRvalid = abort;
    ex = idle_exp();
  endtask

  initial begin
    ex = idle_exp();
    repeat (3) @(posedge i_clk);
    #1;
    chk1("rst_stall", o_stall, 1'b0);
    chk1("rst_memReq", o_memReq, 1'b0);
    chk1("rst_done", o_done, 1'b0);
    chk32("rst_memAddr", o_memAddr, 32'd0);
    chk32("rst_loadData", o_loadData, 32'd0);
    i_rst_n = 1'b1;
    chk_en  = 1'b1;

    chk32("pin_lb", m_load(3'b000, 2'd3, 32'h80FF_1234), 32'hFFFF_FF80);
    chk32("pin_lbu", m_load(3'b100, 2'd3, 32'h80FF_1234), 32'h0000_0080);
    chk32("pin_lhu", m_load(3'b101, 2'd2, 32'h80FF_1234), 32'h0000_80FF);
    chk32("pin_sh_wdata", m_wd(3'b001, 32'h1234_ABCD), 32'hABCD_ABCD);
    chk32("pin_sh_be", {28'd0, m_be(1'b1, 3'b001, 2'd2)}, 32'h0000_000C);

    run_txn(1'b0, 3'b010, 32'h1000_0004, 32'd0, 32'hDEAD_BEEF, 0, 1, 1'b1);
    chk32("lw_data", last_ldata, 32'hDEAD_BEEF);
    run_txn(1'b0, 3'b000, 32'h2000_0003, 32'd0, 32'h80FF_1234, 1, 2, 1'b1);
    chk32("lb_data", last_ldata, 32'hFFFF_FF80);
    run_txn(1'b0, 3'b100, 32'h2000_0003, 32'd0, 32'h80FF_1234, 0, 1, 1'b1);
    chk32("lbu_data", last_ldata, 32'h0000_0080);
    run_txn(1'b0, 3'b101, 32'h2000_0002, 32'd0, 32'h80FF_1234, 2, 1, 1'b1);
    chk32("lhu_data", last_ldata, 32'h0000_80FF);
    run_txn(1'b1, 3'b001, 32'h3000_0002, 32'h1234_ABCD, 32'd0, 4, 1, 1'b0);
    run_txn(1'b0, 3'b010, 32'h1000_0001, 32'd0, 32'd0, 0, 1, 1'b1);
    run_txn(1'b0, 3'b011, 32'h1000_0000, 32'd0, 32'd0, 0, 1, 1'b1);
    run_txn(1'b0, 3'b110, 32'h1000_0003, 32'd0, 32'd0, 0, 1, 1'b1);
    run_txn(1'b1, 3'b100, 32'h1000_0000, 32'd0, 32'd0, 0, 1, 1'b1);
    run_txn(1'b0, 3'b010, 32'h4000_0000, 32'd0, 32'h1111_2222, 0, 1, 1'b0);

    // Reset asserted while a load waits for its response.
    step();
    i_valid = 1'b1; i_isStore = 1'b0; i_funct3 = 3'b010; i_addr = 32'h1000_0008;
    i_memReady = 1'b0; i_memRvalid = 1'b0;
    ex = idle_exp(); ex.stall = 1'b1;
    step();
    i_memReady = 1'b1;
    ex.req = 1'b1; ex.addr = 32'h1000_0008; ex.be = 4'hF;
    step();
    i_memReady = 1'b0;
    ex = idle_exp(); ex.stall = 1'b1;
    step();
    chk_en = 1'b0; i_valid = 1'b0; i_rst_n = 1'b0;
    #1;
    chk1("arst_stall", o_stall, 1'b0);
    chk1("arst_memReq", o_memReq, 1'b0);
    chk1("arst_done", o_done, 1'b0);
    chk1("arst_busError", o_busError, 1'b0);
    chk32("arst_memAddr", o_memAddr, 32'd0);
    chk32("arst_byteEn", {28'd0, o_memByteEn}, 32'd0);
    chk32("arst_loadData", o_loadData, 32'd0);
    repeat (2) step();
    i_rst_n = 1'b1; ex = idle_exp(); chk_en = 1'b1;
    run_txn(1'b0, 3'b010, 32'h1000_000C, 32'd0, 32'hCAFE_F00D, 1, 1, 1'b1);
    chk32("post_rst_lw", last_ldata, 32'hCAFE_F00D);

    for (int t = 0; t < 80; t++) begin
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 5)), int'($urandom_range(1, 4)), $urandom_range(0, 9) != 0);
    end

    step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly downstream of the ALU in the single-cycle core: consumes the ALU result as an effective address and rs2 as store data, and drives a simple req/ready/rvalid data-memory port.
- Performs byte/half/word loads and stores, formats load data with sign or zero extension, and detects misaligned or illegal accesses.
- Stalls the core while a memory transaction is outstanding and aborts on a response timeout.

Parameters:
- TIMEOUT, 256, max cycles from entering REQ until completion before abort; 0 disables the timeout.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  current instruction is a load/store; held stable until o_done, o_misaligned, o_illegal or o_busError
- i_isStore  in  1  1 = store, 0 = load
- i_funct3  in  3  RV32I funct3 of the load/store
- i_addr  in  32  effective address (ALU result)
- i_storeData  in  32  rs2 value
- o_memReq  out  1  memory request valid
- o_memWe  out  1  write enable
- o_memAddr  out  32  word-aligned address, {addr[31:2],2'b00}
- o_memWdata  out  32  lane-replicated store data
- o_memByteEn  out  4  byte enables
- i_memReady  in  1  memory accepts request this cycle
- i_memRvalid  in  1  read data valid
- i_memRdata  in  32  read data
- o_stall  out  1  freeze PC/regfile write
- o_done  out  1  one-cycle completion pulse
- o_loadData  out  32  formatted load result, valid while o_done = 1
- o_misaligned  out  1  one-cycle fault pulse
- o_illegal  out  1  one-cycle fault pulse
- o_busError  out  1  one-cycle timeout pulse

Behaviour:
- Reset: state IDLE, all outputs 0, timeout counter 0. Asserting reset mid-transaction aborts immediately with no completion pulse.
- Legal funct3 values:
  - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- Alignment rules: H requires addr[0] = 0; W requires addr[1:0] = 0.
- Check priority: illegal funct3 is checked before alignment.
- IDLE, i_valid = 1:
  - Illegal access: o_illegal pulses in the same cycle (combinational), no memory access, stay IDLE, o_stall = 0.
  - Misaligned access: o_misaligned pulses the same way, no memory access, stay IDLE, o_stall = 0.
  - Otherwise: latch isStore, funct3, addr[1:0], memAddr, wdata and byteEn into registers, go to REQ, o_stall = 1.
- REQ:
  - o_memReq = 1; fields are driven from registers and stay stable until i_memReady.
  - On i_memReady: a store goes to DONE; a load goes to WAIT.
- WAIT:
  - On i_memRvalid: capture the formatted data into the o_loadData register and go to DONE.
  - The earliest rvalid is the cycle after acceptance; rvalid in the acceptance cycle is ignored.
- DONE: o_done = 1 and o_stall = 0 for exactly one cycle, then IDLE. A new i_valid is evaluated in the following cycle.
- o_stall = 1 whenever (IDLE and i_valid and legal and aligned), or in REQ, or in WAIT.
- Store formatting:
  - SB: byteEn = 4'b0001 << addr[1:0]; wdata = {4{data[7:0]}}.
  - SH: byteEn = 4'b0011 << {addr[1],1'b0}; wdata = {2{data[15:0]}}.
  - SW: byteEn = 4'b1111; wdata = data.
  - Loads: o_memByteEn = 4'b1111, o_memWe = 0.
- Load formatting: select byte rdata[8*addr[1:0] +: 8] or half rdata[16*addr[1] +: 16], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- Timeout:
  - The counter clears on entering REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT: o_busError pulses, go to IDLE with no o_done; o_stall drops the next cycle.
  - A stray late rvalid arriving in IDLE/REQ is ignored.
- o_loadData holds its last value outside DONE; it is only meaningful while o_done = 1.

Test Plan:
- LW addr 0x1000_0004, ready same cycle, rvalid next cycle with 0xDEAD_BEEF -> memAddr 0x1000_0004, byteEn 1111, o_done 3 cycles after i_valid, o_loadData 0xDEAD_BEEF, stall high until DONE.
- LB addr ...03, rdata 0x80FF_1234 -> o_loadData 0xFFFF_FF80; LBU same -> 0x0000_0080; LHU addr ...02 -> 0x0000_80FF.
- SH addr ...02 data 0x1234_ABCD, ready delayed 4 cycles -> req/wdata 0xABCD_ABCD/byteEn 1100 stable all 4 cycles, o_done one cycle after ready, o_memWe = 1.
- LW addr ...01 -> o_misaligned pulse, o_memReq never asserts, o_stall 0; funct3 = 011 -> o_illegal.
- TIMEOUT = 8, load, ready accepted, no rvalid -> o_busError pulse at count 8, no o_done; late rvalid afterwards is ignored.
- Reset asserted in WAIT -> all outputs 0 asynchronously; after release, LW completes normally.
